// File: rtl/i2s_fifo_tx.sv
// i2s_fifo_tx: I2S transmitter that drains L/R sample pairs from an async_fifo
// read port and serialises them as 32-slot frames (16-bit L, 16-bit R, MSB first,
// standard one-bit LRCK delay). Playback starts only once START_LEVEL words are
// buffered. A frame with no complete pair available is muted and counted.
//
// Ports:
//   clk                 audio-domain clock (also the FIFO read clock)
//   resetn              synchronous active-low reset
//   enable              level-sensitive playback enable
//   fifo_can_read       FIFO head word valid
//   fifo_read_data      FIFO head word (alternating L, R)
//   fifo_read_available FIFO fill level (may under-report)
//   fifo_read           pop strobe, one cycle per word
//   i2s_bclk            bit clock, low for the first CLK_DIV cycles of each slot
//   i2s_lrck            word select, 0 = left, 1 = right
//   i2s_sdata           serial data
//   running             high while frames are being played
//   underrun_count      saturating count of muted frames
module i2s_fifo_tx #(
  parameter int CLK_DIV           = 4,
  parameter int START_LEVEL       = 64,
  parameter int BUFFER_ADDR_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       enable,
  input  logic                       fifo_can_read,
  input  logic [15:0]                fifo_read_data,
  input  logic [BUFFER_ADDR_WIDTH:0] fifo_read_available,
  output logic                       fifo_read,
  output logic                       i2s_bclk,
  output logic                       i2s_lrck,
  output logic                       i2s_sdata,
  output logic                       running,
  output logic [15:0]                underrun_count
);

  localparam int CW = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] CYC_LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] CYC_HIGH = CW'(CLK_DIV);
  localparam logic [BUFFER_ADDR_WIDTH:0] START_LVL = (BUFFER_ADDR_WIDTH + 1)'(START_LEVEL);
  localparam logic [BUFFER_ADDR_WIDTH:0] PAIR      = (BUFFER_ADDR_WIDTH + 1)'(2);

  typedef enum logic [1:0] {IDLE, PRIME, FILL, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cyc;
  logic [CW-1:0] cyc_next;
  logic [4:0]    slot;
  logic [4:0]    slot_next;
  logic [31:0]   frame;
  logic [15:0]   hold_l;
  logic [15:0]   hold_r;
  logic          pop_l;
  logic          pop_r;
  logic          slot_end;
  logic          fetch_point;
  logic          starve;
  logic          miss;

  // The pop decision is registered one cycle ahead (pop_l/pop_r), so the
  // fill-level check happens on the last cycle of slot 29 and the two pops
  // land on cycles 0 and 1 of slot 30. The strobe itself is gated by the
  // live can_read/enable/resetn so no word is ever popped without capture.
  always_comb begin
    cyc_next    = cyc + 1'b1;
    slot_next   = slot + 1'b1;
    slot_end    = (cyc == CYC_LAST);
    fetch_point = (state == RUN) && (slot == 5'd29) && slot_end;
    starve      = fetch_point && (fifo_read_available < PAIR);
    miss        = (pop_l || pop_r) && !fifo_can_read;
    fifo_read   = resetn && enable && (pop_l || pop_r) && fifo_can_read;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= IDLE;
      cyc            <= '0;
      slot           <= '0;
      frame          <= '0;
      hold_l         <= '0;
      hold_r         <= '0;
      pop_l          <= 1'b0;
      pop_r          <= 1'b0;
      i2s_bclk       <= 1'b0;
      i2s_lrck       <= 1'b0;
      i2s_sdata      <= 1'b0;
      running        <= 1'b0;
      underrun_count <= '0;
    end else if (!enable) begin
      state     <= IDLE;
      cyc       <= '0;
      slot      <= '0;
      pop_l     <= 1'b0;
      pop_r     <= 1'b0;
      i2s_bclk  <= 1'b0;
      i2s_lrck  <= 1'b0;
      i2s_sdata <= 1'b0;
      running   <= 1'b0;
    end else begin
      // Pair fetch, shared by the initial fill and the per-frame refill.
      // Starvation or a vanished head word mutes the whole pair.
      if ((starve || miss) && (underrun_count != 16'hFFFF))
        underrun_count <= underrun_count + 1'b1;
      if (starve || miss) begin
        hold_l <= '0;
        hold_r <= '0;
      end
      if (pop_l) begin
        pop_l <= 1'b0;
        if (fifo_can_read) begin
          hold_l <= fifo_read_data;
          pop_r  <= 1'b1;
        end
      end
      if (pop_r) begin
        pop_r <= 1'b0;
        if (fifo_can_read)
          hold_r <= fifo_read_data;
      end

      case (state)
        IDLE: state <= PRIME;
        PRIME: begin
          if (fifo_read_available >= START_LVL) begin
            pop_l <= 1'b1;
            state <= FILL;
          end
        end
        FILL: begin
          if (miss || pop_r) begin
            state    <= RUN;
            running  <= 1'b1;
            cyc      <= '0;
            slot     <= '0;
            i2s_bclk <= 1'b0;
            i2s_lrck <= 1'b0;
            if (miss) begin
              frame     <= '0;
              i2s_sdata <= 1'b0;
            end else begin
              frame     <= {hold_l, fifo_read_data};
              i2s_sdata <= hold_l[15];
            end
          end
        end
        RUN: begin
          if (fetch_point && !starve)
            pop_l <= 1'b1;
          if (slot_end) begin
            cyc      <= '0;
            slot     <= slot_next;
            i2s_bclk <= 1'b0;
            // LRCK leads the word by one slot (I2S delay).
            i2s_lrck <= (slot_next >= 5'd15) && (slot_next != 5'd31);
            if (slot_next == 5'd0) begin
              frame     <= {hold_l, hold_r};
              i2s_sdata <= hold_l[15];
            end else begin
              i2s_sdata <= frame[5'd31 - slot_next];
            end
          end else begin
            cyc      <= cyc_next;
            i2s_bclk <= (cyc_next >= CYC_HIGH);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_fifo_tx.sv
// Bench for i2s_fifo_tx: a queue-based FIFO model feeds the DUT, a monitor
// deserialises each completed I2S frame and compares it against expected
// frames queued by the stimulus process.
module tb_i2s_fifo_tx;
  localparam int CLK_DIV     = 2;
  localparam int START_LEVEL = 4;
  localparam int AW          = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic        fifo_can_read = 1'b0;
  logic [15:0] fifo_read_data = '0;
  logic [AW:0] fifo_read_available = '0;
  logic        fifo_read;
  logic        i2s_bclk;
  logic        i2s_lrck;
  logic        i2s_sdata;
  logic        running;
  logic [15:0] underrun_count;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] fq[$];
  int          pop_total = 0;
  logic        pop_seen = 1'b0;

  typedef struct packed {
    logic [31:0] data;
    logic [15:0] ucnt;
  } exp_t;
  exp_t sb[$];
  int   frames_done = 0;
  int   pos = 0;

  i2s_fifo_tx #(
    .CLK_DIV(CLK_DIV),
    .START_LEVEL(START_LEVEL),
    .BUFFER_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .enable(enable),
    .fifo_can_read(fifo_can_read),
    .fifo_read_data(fifo_read_data),
    .fifo_read_available(fifo_read_available),
    .fifo_read(fifo_read),
    .i2s_bclk(i2s_bclk),
    .i2s_lrck(i2s_lrck),
    .i2s_sdata(i2s_sdata),
    .running(running),
    .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input logic [31:0] d, input logic [15:0] u);
    exp_t e;
    e.data = d;
    e.ucnt = u;
    sb.push_back(e);
  endtask

  // Cycle n counts from the start of slot 0 of the first frame.
  task automatic goto(input int target);
    repeat (target - pos) @(posedge clk);
    pos = target;
  endtask

  // FIFO model: pops take effect just after the edge that ended the pop cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (pop_seen && fq.size() > 0) begin
        void'(fq.pop_front());
        pop_total++;
      end
      fifo_can_read       = (fq.size() > 0);
      fifo_read_data      = (fq.size() > 0) ? fq[0] : 16'h0000;
      fifo_read_available = (AW + 1)'(fq.size());
    end
  end

  // Monitor: frame deserialiser and scoreboard checker.
  initial begin
    int          slot;
    int          ncyc;
    int          last_done;
    bit          first;
    logic        prev_bclk;
    logic [31:0] dbits;
    logic [31:0] lbits;
    exp_t        e;
    slot = 0; ncyc = 0; last_done = 0; first = 1'b1; prev_bclk = 1'b0;
    dbits = '0; lbits = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      pop_seen = fifo_read;
      if (fifo_read) check("pop_needs_can_read", fifo_can_read, 1'b1);
      if (!running) begin
        slot = 0;
        prev_bclk = 1'b0;
        first = 1'b1;
      end else begin
        if (i2s_bclk && !prev_bclk) begin
          dbits = {dbits[30:0], i2s_sdata};
          lbits = {lbits[30:0], i2s_lrck};
          slot++;
          if (slot == 32) begin
            slot = 0;
            frames_done++;
            if (sb.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL unexpected_frame: got %h expected none", dbits);
            end else begin
              e = sb.pop_front();
              check("frame_data", dbits, e.data);
              check("lrck_pattern", lbits, 32'h0001FFFE);
              check("underrun_count", underrun_count, e.ucnt);
            end
            if (!first) check("frame_period", ncyc - last_done, 64 * CLK_DIV);
            first = 1'b0;
            last_done = ncyc;
          end
        end
        prev_bclk = i2s_bclk;
      end
    end
  end

  initial begin
    #200000;
    vectors++;
    miscompares++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [31:0] kept;

    // Reset with enable high and a full FIFO.
    resetn = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) fq.push_back(16'(16'h1111 * (i + 1)));
    repeat (5) begin
      @(negedge clk);
      check("reset_outputs",
            {fifo_read, i2s_bclk, i2s_lrck, i2s_sdata, running, underrun_count}, '0);
    end
    @(posedge clk);
    enable = 1'b0;
    fq.delete();
    @(posedge clk);
    resetn = 1'b1;
    repeat (2) @(posedge clk);

    // Sub-threshold: 3 words buffered, no playback.
    fq.push_back(16'hA5C3);
    fq.push_back(16'h3C5A);
    fq.push_back(16'h1234);
    expect_frame(32'hA5C3_3C5A, 16'd0);
    expect_frame(32'h1234_8001, 16'd1);
    expect_frame(32'h0000_0000, 16'd2);
    expect_frame(32'h0000_0000, 16'd2);
    enable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("prime_hold", {fifo_read, running}, 2'b00);
    end

    // Fourth word: pops on the next two cycles, then slot 0.
    @(posedge clk);
    fq.push_back(16'h8001);
    @(negedge clk); check("pop_l_not_yet", fifo_read, 1'b0);
    @(negedge clk); check("pop_l", fifo_read, 1'b1);
    @(negedge clk); check("pop_r", fifo_read, 1'b1);
    @(negedge clk);
    check("run_entry", {running, fifo_read, i2s_lrck, i2s_sdata, i2s_bclk}, 5'b10010);
    @(posedge clk);
    pos = 1;

    // Refill after two muted frames.
    goto(3 * 128 + 40);
    fq.push_back(16'hBEEF);
    fq.push_back(16'h0F0F);
    expect_frame(32'hBEEF_0F0F, 16'd3);
    expect_frame(32'h0000_0000, 16'd4);

    // A lone word must stay put.
    goto(4 * 128 + 40);
    fq.push_back(16'h7777);
    goto(5 * 128 + 124);
    @(negedge clk);
    kept = {16'(fq.size()), (fq.size() > 0) ? fq[0] : 16'h0000};
    check("odd_word_kept", kept, {16'd1, 16'h7777});

    // Disable in the middle of slot 20.
    goto(6 * 128 + 82);
    enable = 1'b0;
    @(posedge clk);
    pos++;
    @(negedge clk);
    check("disable_outputs", {fifo_read, i2s_bclk, i2s_lrck, i2s_sdata, running}, '0);
    check("underrun_kept", underrun_count, 16'd4);

    // Re-enable: threshold applies again.
    repeat (3) @(posedge clk);
    enable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("reprime_hold", {fifo_read, running}, 2'b00);
    end
    @(posedge clk);
    fq.push_back(16'h8888);
    fq.push_back(16'h9999);
    fq.push_back(16'hAAAA);
    expect_frame(32'h7777_8888, 16'd4);
    expect_frame(32'h9999_AAAA, 16'd5);
    n = 0;
    while (!running && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reprime_start", running, 1'b1);
    n = 0;
    while (frames_done < 8 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("frames_done", frames_done, 8);
    check("pop_total", pop_total, 10);
    check("scoreboard_drained", sb.size(), 0);

    // Reset in the middle of a frame.
    repeat (30) @(posedge clk);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midframe_reset",
          {fifo_read, i2s_bclk, i2s_lrck, i2s_sdata, running, underrun_count}, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
